// File: rtl/hilo_regs.sv
// hilo_regs
// ---------
// HI/LO result registers that sit directly after the integer multiplier.
// Internally the block counts the multiplier's fixed pipeline latency and
// captures the 2*BIT_WIDTH product into {HI,LO} when that count runs out. It
// also serves MFHI/MFLO reads and MTHI/MTLO writes, and stalls those requests
// while a product is still in flight.
//
// Parameters
//   BIT_WIDTH  data width; the product is 2*BIT_WIDTH wide
//   DELAY      multiplier latency in cycles (0 = combinational product).
//              This must match the DELAY of the multiplier that drives prod.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-low reset
//   mult_start  a MULT is issued this cycle
//   prod        multiplier output; upper half goes to HI, lower half to LO
//   mthi/mtlo   write wr_data into HI / LO
//   wr_data     move-to data
//   mfhi/mflo   read request for HI / LO (mfhi wins if both are set)
//   rd_data     registered read data
//   rd_valid    one-cycle pulse: rd_data holds a fresh read result
//   busy        a product is pending (decoded from the counter register)
//   stall       combinational: this cycle's move request is refused
//   hi/lo       current HI/LO contents

module hilo_regs #(
    parameter int BIT_WIDTH = 32,
    parameter int DELAY     = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mult_start,
    input  logic [2*BIT_WIDTH-1:0] prod,
    input  logic                   mthi,
    input  logic                   mtlo,
    input  logic [BIT_WIDTH-1:0]   wr_data,
    input  logic                   mfhi,
    input  logic                   mflo,
    output logic [BIT_WIDTH-1:0]   rd_data,
    output logic                   rd_valid,
    output logic                   busy,
    output logic                   stall,
    output logic [BIT_WIDTH-1:0]   hi,
    output logic [BIT_WIDTH-1:0]   lo
);

    logic                 w_busy;
    logic                 w_capture;
    logic                 w_req;
    logic                 w_stall;
    logic                 w_rd_en;
    logic                 w_wr_hi;
    logic                 w_wr_lo;

    logic [BIT_WIDTH-1:0] r_hi;
    logic [BIT_WIDTH-1:0] r_lo;
    logic [BIT_WIDTH-1:0] r_rd_data;
    logic                 r_rd_valid;

    // ------------------------------------------------------------------
    // Latency tracking
    // ------------------------------------------------------------------
    generate
        if (DELAY == 0) begin : g_comb_mult
            // The product is already valid in the issue cycle, so it is
            // captured on that edge and nothing is ever pending.
            assign w_busy    = 1'b0;
            assign w_capture = rst & mult_start;
        end else begin : g_pipe_mult
            localparam int                 CNT_W    = $clog2(DELAY + 1);
            localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(DELAY);
            localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_cnt <= '0;
                end else if (mult_start) begin
                    // A new MULT restarts the count and drops whatever was
                    // pending before it.
                    r_cnt <= CNT_LOAD;
                end else if (r_cnt != '0) begin
                    r_cnt <= r_cnt - CNT_ONE;
                end
            end

            assign w_busy = (r_cnt != '0);

            // The capture on the last count is cancelled when a new MULT
            // reloads the counter on the same edge; that product is stale.
            assign w_capture = rst & (r_cnt == CNT_ONE) & ~mult_start;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------
    // A move request is refused while a product is pending and also in the
    // MULT issue cycle itself, so HI/LO cannot be read or overwritten ahead
    // of the capture. Because of that, a capture and a move-to write can
    // never happen on the same edge.
    assign w_req   = mthi | mtlo | mfhi | mflo;
    assign w_stall = rst & w_req & (w_busy | mult_start);

    assign w_rd_en = rst & ~w_stall & (mfhi | mflo);
    assign w_wr_hi = rst & ~w_stall & mthi;
    assign w_wr_lo = rst & ~w_stall & mtlo;

    // ------------------------------------------------------------------
    // HI/LO registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_capture) begin
            r_hi <= prod[2*BIT_WIDTH-1:BIT_WIDTH];
            r_lo <= prod[BIT_WIDTH-1:0];
        end else begin
            if (w_wr_hi) begin
                r_hi <= wr_data;
            end
            if (w_wr_lo) begin
                r_lo <= wr_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read port
    // ------------------------------------------------------------------
    // The read samples HI/LO before any write on the same edge takes effect,
    // so a read paired with a write returns the old value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_en;
            if (w_rd_en) begin
                r_rd_data <= mfhi ? r_hi : r_lo;
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign busy     = w_busy;
    assign stall    = w_stall;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: doc/hilo_regs.md
# hilo_regs

Result-holding stage directly downstream of the integer multiplier. It tracks the multiplier's fixed pipeline latency and captures the 2×BIT_WIDTH product into the HI/LO architectural registers. It serves MFHI/MFLO reads and MTHI/MTLO writes, and raises a stall interlock toward the decode/issue stage while a product is still in flight.

## Interface

Parameters:
- BIT_WIDTH, 32, data width; the product is 2×BIT_WIDTH.
- DELAY, 0, multiplier latency in cycles. Must equal the DELAY of the multiplier instance feeding `prod`. 0 means a combinational product.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- mult_start  in  1  MULT issued this cycle; operands presented to the multiplier this cycle.
- prod  in  2×BIT_WIDTH  multiplier output; upper half goes to HI, lower half to LO.
- mthi  in  1  write `wr_data` to HI.
- mtlo  in  1  write `wr_data` to LO.
- wr_data  in  BIT_WIDTH  move-to data.
- mfhi  in  1  read request for HI.
- mflo  in  1  read request for LO.
- rd_data  out  BIT_WIDTH  registered read data.
- rd_valid  out  1  one-cycle pulse; `rd_data` is valid.
- busy  out  1  a product is pending (registered).
- stall  out  1  combinational; the current mthi/mtlo/mfhi/mflo request is refused this cycle.
- hi, lo  out  BIT_WIDTH each  current HI/LO register contents.

## Operation

- Internal state: HI, LO, and a pending counter `cnt` of width clog2(DELAY+1). There is no counter when DELAY=0.
- **DELAY=0:** on `mult_start`, {HI,LO} <= `prod` at the same edge. `busy` is never asserted.
- **DELAY=D>0, launch:** on `mult_start`, `cnt` <= D.
- **DELAY=D>0, countdown:** while `cnt`≠0, `cnt` decrements each edge. At the edge where `cnt`==1, {HI,LO} <= `prod`.
- **busy:** `busy` = (`cnt`≠0).
- **Stall rule:** `stall` = `busy` | `mult_start`, qualified by any of mthi/mtlo/mfhi/mflo being asserted.
  - A stalled request has no effect. The requester holds it until `stall` drops.
  - With no request pending, `stall`=0.
- **Read:**
  - Unstalled `mfhi` → `rd_data` <= HI and `rd_valid` <= 1 at the next edge.
  - Unstalled `mflo` → same, with LO.
  - `mfhi` and `mflo` together: `mfhi` wins.
  - `rd_valid` is 0 on every other cycle; `rd_data` holds its last value.
- **Write:** unstalled `mthi` writes HI and unstalled `mtlo` writes LO, both at the edge. Both asserted together write both.
- **Read and write in the same cycle:** `rd_data` returns the pre-write value.
- **New MULT while busy:** `mult_start` with `cnt`≠0 reloads `cnt` <= D. The old pending capture is cancelled, including when `cnt`==1 at that same edge. HI/LO keep their prior value until the new capture.
- **Capture vs. writes:** a capture and a move-to write never coincide, because writes stall while busy.

## Timing

- **Reset (`rst`=0 at an edge):**
  - HI=0, LO=0, `cnt`=0.
  - `rd_data`=0, `rd_valid`=0, `busy`=0.
  - Requests are ignored.
  - `stall` is forced 0 during reset.
- **Reset mid-operation:** a pending product is discarded and HI/LO become 0.
- **MULT at edge E0, DELAY=D>0:**
  - `busy`=1 for cycles 1..D.
  - HI/LO are updated at edge E_D and visible from cycle D+1.
  - The earliest MFHI issued in cycle D+1 gets `rd_valid` in cycle D+2.
- **DELAY=0:** a MULT at E0 is visible in cycle 1. A MFHI in the MULT's own cycle stalls for exactly one cycle.
- **Read latency:** 1 cycle from the unstalled request to `rd_valid`.
- **Throughput:** back-to-back unstalled reads are allowed, one per cycle.

## Test plan

1. **Reset:** assert `rst`=0 for 2 cycles with mfhi=1 → rd_valid=0, stall=0, hi=lo=0, busy=0.
2. **MULT then read (BIT_WIDTH=32, DELAY=2):** mult_start with prod=64'h0000_0003_FFFF_FFFE, then mfhi held from the next cycle → busy=1 for 2 cycles, stall=1 for those 2 cycles, hi=32'h3, then rd_valid=1 with rd_data=32'h0000_0003.
3. **Move-to writes:** mthi with wr_data=32'hDEAD_BEEF, then mflo+mtlo in the same cycle with wr_data=32'h1234_5678 (LO previously 0) → hi=DEAD_BEEF; rd_data=0 (old LO); lo=1234_5678 next cycle.
4. **MULT restart (DELAY=2):** mult_start (A), then mult_start (B) one cycle later → only B's prod is captured, 2 cycles after B; HI/LO never show A; busy stays 1 for 3 consecutive cycles.
5. **DELAY=0:** mult_start with mfhi in the same cycle and prod=64'h0000_0005_0000_0007 → stall=1 for one cycle, then rd_data=5 with rd_valid=1 the cycle after.
6. **Reset mid-operation (DELAY=3):** rst=0 one cycle after mult_start → busy=0 and hi=lo=0 after reset, with no later capture.
